// File: rtl/bram_tdp_model.sv
// Behavioural true-dual-port block RAM: byte-lane writes, 1/2-cycle reads, per-port write mode.
// Cross-port writes to one word give port A priority on shared lanes; a reader racing a writer sees the old word.
module bram_tdp_model #(
  parameter int DATA_W       = 32,
  parameter int BYTE_W       = 8,
  parameter int ADDR_W       = 7,
  parameter int DEPTH        = 128,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE_A = 0,
  parameter int WRITE_MODE_B = 0,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  localparam int WE_W = DATA_W / BYTE_W
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              ena,
  input  logic [WE_W-1:0]   wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              valida,
  input  logic              enb,
  input  logic [WE_W-1:0]   web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb,
  output logic              validb,
  output logic              collision
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              a_inr, b_inr, same, a_wr, b_wr;
  logic [DATA_W-1:0] old_a, old_b, mrg_a, mrg_b, a_word;
  logic [DATA_W-1:0] s1a_dat, s1b_dat;
  logic              s1a_vld, s1b_vld;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] base,
                                               input logic [DATA_W-1:0] din,
                                               input logic [WE_W-1:0]   we);
    logic [DATA_W-1:0] r;
    r = base;
    for (int i = 0; i < WE_W; i++)
      if (we[i]) r[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
    return r;
  endfunction

  // mode 0 read-first, 1 write-first, 2 no-change (holds the previous capture)
  function automatic logic [DATA_W-1:0] rd_next(input int mode,
                                                 input logic [DATA_W-1:0] hold,
                                                 input logic [DATA_W-1:0] old,
                                                 input logic [DATA_W-1:0] mrg,
                                                 input logic wr);
    if (wr && mode == 2) return hold;
    if (wr && mode == 1) return mrg;
    return old;
  endfunction

  always_comb begin
    a_inr  = ({1'b0, addra} < DEPTH_L);
    b_inr  = ({1'b0, addrb} < DEPTH_L);
    old_a  = a_inr ? mem[addra] : '0;
    old_b  = b_inr ? mem[addrb] : '0;
    mrg_a  = a_inr ? merge(old_a, dina, wea) : '0;
    mrg_b  = b_inr ? merge(old_b, dinb, web) : '0;
    same   = a_inr && b_inr && (addra == addrb);
    a_wr   = ena && a_inr && (|wea);
    b_wr   = enb && b_inr && (|web);
    // A's word folds in B's lanes first so B-only lanes survive a shared-address write
    a_word = merge((same && b_wr) ? mrg_b : old_a, dina, wea);
  end

  // Array writes ignore rsta; A is applied last and wins on a shared address.
  always_ff @(posedge clka) begin
    if (b_wr) mem[addrb] <= mrg_b;
    if (a_wr) mem[addra] <= a_word;
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      s1a_dat   <= RST_VAL;
      s1b_dat   <= RST_VAL;
      s1a_vld   <= 1'b0;
      s1b_vld   <= 1'b0;
      collision <= 1'b0;
    end else begin
      s1a_vld   <= ena;
      s1b_vld   <= enb;
      if (ena) s1a_dat <= rd_next(WRITE_MODE_A, s1a_dat, old_a, mrg_a, |wea);
      if (enb) s1b_dat <= rd_next(WRITE_MODE_B, s1b_dat, old_b, mrg_b, |web);
      collision <= ena && enb && same && ((|wea) || (|web));
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clka) begin
        if (rsta) begin
          douta  <= RST_VAL;
          doutb  <= RST_VAL;
          valida <= 1'b0;
          validb <= 1'b0;
        end else begin
          douta  <= s1a_dat;
          doutb  <= s1b_dat;
          valida <= s1a_vld;
          validb <= s1b_vld;
        end
      end
    end else begin : g_lat1
      assign douta  = s1a_dat;
      assign doutb  = s1b_dat;
      assign valida = s1a_vld;
      assign validb = s1b_vld;
    end
  endgenerate

endmodule

// File: doc/bram_tdp_model.md
Name: bram_tdp_model

Overview:
- Parametrised behavioural true-dual-port block-RAM model; simulation successor to the fixed-geometry RAM stand-ins that return constant zero (main memory, PHT, BTB, dcache, tag RAM).
- Real storage, byte-lane writes, 1- or 2-cycle read latency, per-port write mode, defined cross-port collision semantics, read-valid tracking.
- Instantiated under cache/predictor wrappers in place of vendor IP for functional simulation.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, bits per write-enable lane; WE_W = DATA_W/BYTE_W.
- ADDR_W, 7, address width.
- DEPTH, 128, number of words; DEPTH <= 2**ADDR_W.
- READ_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- WRITE_MODE_A, 0, port A same-port read-during-write: 0 read-first, 1 write-first, 2 no-change.
- WRITE_MODE_B, 0, same encoding as WRITE_MODE_A, for port B.
- RST_VAL, 0, DATA_W-bit value loaded into output registers on reset.

Ports:
- clka  in  1  single clock for both ports; rising edge.
- rsta  in  1  synchronous active-high reset; clears output/pipeline registers only.
- ena  in  1  port A enable.
- wea  in  WE_W  port A byte-lane write enables.
- addra  in  ADDR_W  port A address.
- dina  in  DATA_W  port A write data.
- douta  out  DATA_W  port A read data.
- valida  out  1  douta holds data from an enabled port A access.
- enb  in  1  port B enable.
- web  in  WE_W  port B byte-lane write enables.
- addrb  in  ADDR_W  port B address.
- dinb  in  DATA_W  port B write data.
- doutb  out  DATA_W  port B read data.
- validb  out  1  doutb holds data from an enabled port B access.
- collision  out  1  registered flag: previous cycle had both ports enabled on the same in-range address with at least one writing.

Behaviour:
- Memory array is initialised to all zeros at time 0. rsta never alters array contents.
- Reset (rsta=1 at edge): douta/doutb <= RST_VAL, valida/validb <= 0, collision <= 0, all stage-1 registers cleared. Reset overrides enables for output registers. Writes presented during reset with en=1 still commit to the array.
- Write: at an edge with enX=1 and addrX < DEPTH, each lane i with weX[i]=1 stores dinX[i*BYTE_W +: BYTE_W]. Lanes with weX[i]=0 are unchanged.
- Read, stage 1: on an edge with enX=1, the stage-1 register captures read data per the write mode and sets stage-1 valid. With enX=0 the stage-1 data holds and stage-1 valid is cleared.
- Write-mode rules when weX != 0:
  - Read-first: the old word is captured.
  - Write-first: the merged word is captured (new data on enabled lanes, old data elsewhere).
  - No-change: stage-1 data holds its previous value and stage-1 valid is set.
- Out of range (addrX >= DEPTH): the write is dropped and the read captures zero. Valid still asserts.
- READ_LATENCY=1: doutX/validX are the stage-1 registers; data appears on the edge after the request.
- READ_LATENCY=2: a second register stage copies stage 1 unconditionally every cycle; data appears two edges after the request.
- Cross-port, same in-range address, same edge:
  - Both writing: lanes enabled on both ports take port A data; all other lanes follow the normal per-port rule.
  - One reading, the other writing: the reader always gets the old word, regardless of its own write mode.
  - collision is asserted one edge later.
- Two reads of the same address: no collision, both ports return the word.
- Different addresses: the ports are fully independent.
- No X propagation: outputs are never X after the first reset.

Test Plan:
- Reset then idle: rsta=1 for 2 cycles with RST_VAL=32'hDEAD_BEEF -> douta=doutb=32'hDEAD_BEEF, valida=validb=0, collision=0.
- Byte write + latency:
  - Setup: READ_LATENCY=1; A writes addr 5, wea=4'b0101, dina=32'h1122_3344 onto zeroed memory.
  - Action: read addr 5 on the next cycle.
  - Expected: douta=32'h0022_0044 and valida=1 one edge after the read. With READ_LATENCY=2 the same result appears two edges after the read.
- Write modes:
  - Setup: addr 9 holds 32'hAAAA_AAAA; A writes 32'h5555_5555, wea=4'hF.
  - Expected douta one edge later: mode 0 -> 32'hAAAA_AAAA; mode 1 -> 32'h5555_5555; mode 2 -> prior douta value; array holds 32'h5555_5555 in all modes.
- Collision:
  - Write/write: A writes 32'h1111_1111 and B writes 32'h2222_2222 to addr 3, both wea/web=4'hF, same edge -> addr 3 = 32'h1111_1111, collision=1 on the following cycle.
  - Write/read: A writes 32'h7777_7777 to addr 4 (old value 32'h0000_00AB) while B reads addr 4 -> doutb=32'h0000_00AB.
- Out of range and enable: DEPTH=100, ADDR_W=7, write 32'hFFFF_FFFF to addr 110 then read it -> read returns 0 and no in-range word changes. With ena=0 for 3 cycles -> douta holds, valida=0.
- Reset mid-operation: assert rsta on the same edge as an A write of 32'hCAFE_F00D to addr 2 -> douta=RST_VAL and valida=0 that cycle; a later read of addr 2 returns 32'hCAFE_F00D.
